// File: rtl/data_sram_like_responder.sv
// Responder for the data_sram req/addr_ok/data_ok handshake: in-order request FIFO,
// programmable wait states per request, and one access per request on a 1-cycle SRAM.
module data_sram_like_responder #(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 0,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CW      = $clog2(DEPTH + 1);
  localparam bit         HAS_LAT = (LATENCY != 0);
  localparam logic [3:0] LAT_M1  = HAS_LAT ? 4'(LATENCY - 1) : 4'd0;

  typedef struct packed {
    logic              wr;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} state_t;

  req_t          q [DEPTH];
  req_t          head;
  logic [PW-1:0] rd_ptr, wr_ptr, rd_inc, wr_inc;
  logic [CW-1:0] count, count_next;
  state_t        state;
  logic [3:0]    wait_cnt;
  logic          resp_wr;
  logic [31:0]   rdata_q;
  logic          push, pop, start, go_issue;
  logic          unused_ok;

  assign unused_ok  = ^{data_sram_size, data_sram_addr};

  assign push       = data_sram_req & data_sram_addr_ok;
  assign pop        = (state == RESP);
  assign count_next = count + CW'(push) - CW'(pop);
  assign rd_inc     = (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
  assign wr_inc     = (DEPTH == 1) ? '0 : wr_ptr + 1'b1;

  // Leaving RESP the popped entry still sits at rd_ptr, so the next access comes from rd_inc.
  assign head     = pop ? q[rd_inc] : q[rd_ptr];
  assign start    = (state == IDLE && count != '0) || (pop && count != CW'(1));
  assign go_issue = (state == WAIT && wait_cnt == 4'd0) || (start && !HAS_LAT);

  always_ff @(posedge clk) begin
    if (push)
      q[wr_ptr] <= '{data_sram_wr, data_sram_wstrb, data_sram_addr[ADDR_W+1:2], data_sram_wdata};
  end

  // addr_ok is a pure function of the registered occupancy, never of a same-cycle pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      data_sram_addr_ok <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_inc;
      if (pop)  rd_ptr <= rd_inc;
      count             <= count_next;
      data_sram_addr_ok <= (count_next < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      wait_cnt          <= 4'd0;
      ram_en            <= 1'b0;
      ram_we            <= 4'd0;
      ram_addr          <= '0;
      ram_wdata         <= 32'd0;
      data_sram_data_ok <= 1'b0;
      resp_wr           <= 1'b0;
    end else begin
      ram_en            <= 1'b0;
      ram_we            <= 4'd0;
      data_sram_data_ok <= 1'b0;
      if (go_issue) begin
        state     <= ISSUE;
        ram_en    <= 1'b1;
        ram_we    <= head.wr ? head.wstrb : 4'd0;
        ram_addr  <= head.waddr;
        ram_wdata <= head.wdata;
      end else if (start) begin
        state    <= WAIT;
        wait_cnt <= LAT_M1;
      end else begin
        case (state)
          WAIT:  wait_cnt <= wait_cnt - 4'd1;
          ISSUE: begin
            state             <= RESP;
            data_sram_data_ok <= 1'b1;
            resp_wr           <= head.wr;
          end
          RESP:    state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end

  // Load data comes straight off the SRAM during RESP and is held afterwards.
  assign data_sram_rdata = data_sram_data_ok ? (resp_wr ? 32'd0 : ram_rdata) : rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  rdata_q <= 32'd0;
    else if (data_sram_data_ok) rdata_q <= data_sram_rdata;
  end

endmodule
